// File: rtl/pio_in_edge_irq.sv
// pio_in_edge_irq: Avalon-MM input PIO with per-bit rise/fall edge selection,
// write-1-to-clear edge capture, level IRQ and an optional debounce filter.
// Optional feature macro: PIO_IN_DEBOUNCE_EN (builds per-channel debounce
// counters and the DBNC_PERIOD register; otherwise q is s registered once).
module pio_in_edge_irq #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DBNC_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    typedef enum logic [2:0] {
        ADDR_DATA     = 3'd0,
        ADDR_RISE_EN  = 3'd1,
        ADDR_IRQ_MASK = 3'd2,
        ADDR_CAPTURE  = 3'd3,
        ADDR_FALL_EN  = 3'd4,
        ADDR_DBNC     = 3'd5,
        ADDR_STATUS   = 3'd6,
        ADDR_RSVD     = 3'd7
    } reg_addr_e;

    logic             wr_en;
    logic [WIDTH-1:0] sync_ff [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] capture;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] w1c;
    logic [31:0]      rd_nxt;
    logic             unused_wdata;

    assign wr_en        = chipselect && !write_n;
    assign unused_wdata = &{1'b0, writedata};

    // Synchroniser chain: in_port -> sync_ff[0] -> ... -> s
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_ff[k] <= '0;
            end
        end else begin
            sync_ff[0] <= in_port;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_ff[k] <= sync_ff[k-1];
            end
        end
    end

    assign s = sync_ff[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
    logic [DBNC_W-1:0] dbnc_period;
    logic [DBNC_W-1:0] cnt [WIDTH];

    // Next filtered value: a channel flips once its counter has reached P.
    // ">=" rather than "==" so a period lowered below a running count
    // still releases on the next mismatching cycle instead of wrapping.
    always_comb begin
        q_nxt = q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if ((s[i] != q[i]) && (cnt[i] >= dbnc_period)) begin
                q_nxt[i] = s[i];
            end
        end
    end

    // Per-channel debounce counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (s[i] == q[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] >= dbnc_period) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DBNC_W'(1);
                end
            end
        end
    end

    // Debounce period register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dbnc_period <= '0;
        end else if (wr_en && (address == ADDR_DBNC)) begin
            dbnc_period <= writedata[DBNC_W-1:0];
        end
    end
`else
    logic [DBNC_W-1:0] unused_period;

    assign unused_period = '0;
    assign q_nxt         = s;
`endif

    // Filtered input register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else begin
            q <= q_nxt;
        end
    end

    assign edge_set = (q_nxt & ~q & rise_en) | (~q_nxt & q & fall_en);
    assign w1c      = (wr_en && (address == ADDR_CAPTURE)) ? writedata[WIDTH-1:0] : '0;

    // Control registers and edge capture (a new edge overrides a same-cycle clear)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_en  <= '0;
            fall_en  <= '0;
            irq_mask <= '0;
            capture  <= '0;
        end else begin
            if (wr_en && (address == ADDR_RISE_EN)) begin
                rise_en <= writedata[WIDTH-1:0];
            end
            if (wr_en && (address == ADDR_IRQ_MASK)) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            if (wr_en && (address == ADDR_FALL_EN)) begin
                fall_en <= writedata[WIDTH-1:0];
            end
            capture <= (capture & ~w1c) | edge_set;
        end
    end

    assign irq = |(capture & irq_mask);

    // Read mux
    always_comb begin
        rd_nxt = '0;
        case (address)
            ADDR_DATA:     rd_nxt[WIDTH-1:0] = q;
            ADDR_RISE_EN:  rd_nxt[WIDTH-1:0] = rise_en;
            ADDR_IRQ_MASK: rd_nxt[WIDTH-1:0] = irq_mask;
            ADDR_CAPTURE:  rd_nxt[WIDTH-1:0] = capture;
            ADDR_FALL_EN:  rd_nxt[WIDTH-1:0] = fall_en;
`ifdef PIO_IN_DEBOUNCE_EN
            ADDR_DBNC:     rd_nxt[DBNC_W-1:0] = dbnc_period;
`else
            ADDR_DBNC:     rd_nxt = '0;
`endif
            ADDR_STATUS: begin
                rd_nxt[0]    = irq;
                rd_nxt[13:8] = 6'(WIDTH);
            end
            ADDR_RSVD:     rd_nxt = '0;
            default:       rd_nxt = '0;
        endcase
    end

    // Registered read data, updated every cycle regardless of chipselect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_nxt;
        end
    end

endmodule

// File: doc/pio_in_edge_irq.md
# pio_in_edge_irq

Parametrised Avalon-MM input PIO with per-bit rising/falling edge selection, per-bit write-1-to-clear edge capture, an optional programmable debounce filter and a level IRQ. It sits between board-level inputs (switches, buttons, status pins) and the Nios II data bus. It replaces fixed-width, any-edge input ports whose capture register clears as a whole.

## Interface
Parameters:
- WIDTH, 8, number of input channels (1..32)
- SYNC_STAGES, 2, synchroniser flops per channel (2..4)
- DBNC_W, 16, debounce period register/counter width (1..32)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  register word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  WIDTH  asynchronous external inputs
- readdata  out  32  registered read data
- irq  out  1  level interrupt, active-high

## Operation
Register map (word addresses; unused readdata bits read 0):
- 0 DATA (RO): filtered input value q[WIDTH-1:0].
- 1 RISE_EN (RW): bit i=1 makes a 0→1 transition of q[i] set CAPTURE[i].
- 2 IRQ_MASK (RW): per-bit interrupt enable.
- 3 CAPTURE (R/W1C): writing 1 to bit i clears it; writing 0 has no effect.
- 4 FALL_EN (RW): bit i=1 makes a 1→0 transition of q[i] set CAPTURE[i].
- 5 DBNC_PERIOD (RW): debounce period P in [DBNC_W-1:0]. See Configuration.
- 6 STATUS (RO): bit0 = irq; bits[13:8] = WIDTH.
- 7: reads 0, writes ignored.

Behaviour:
- A write is accepted when chipselect && !write_n. Writes to RO addresses are ignored.
- Each in_port bit passes through SYNC_STAGES flops to give s[i].
- Per-channel debounce: counter cnt[i] clears whenever s[i]==q[i]. While s[i]!=q[i]: if cnt[i]==P then q[i]<=s[i] and cnt[i]<=0; otherwise cnt[i]++.
- P=0 means q[i] follows s[i] one cycle later.
- Writing DBNC_PERIOD does not clear in-flight counters. If a new P is at or below a running cnt, q updates on the next cycle where s!=q, and cnt restarts.
- CAPTURE[i] sets on the same clock edge that q[i] changes, if the direction is enabled. RISE_EN and FALL_EN both 1 means any edge.
- Simultaneous W1C clear and new set on the same bit: set wins.
- irq = |(CAPTURE & IRQ_MASK), combinational from registers.

## Timing
- Reset values: readdata=0, irq=0, q=0, all sync flops=0, cnt=0, RISE_EN=FALL_EN=IRQ_MASK=CAPTURE=0, DBNC_PERIOD=0.
- Reset is asynchronous on assertion. Reset mid-debounce discards the count.
- An input held high across reset release produces a 0→1 q transition after synchronisation. It is captured only if RISE_EN is already set.
- Read latency: 1 clock. readdata is registered every cycle from address, independent of chipselect.
- Pin-to-q latency for a stable change: SYNC_STAGES + P + 1 clocks. CAPTURE and irq assert the same cycle as q changes.
- A glitch shorter than P+1 synchronised cycles produces no q change and no capture.

## Configuration
- PIO_IN_DEBOUNCE_EN defined: debounce counters and the DBNC_PERIOD register are built as described.
- PIO_IN_DEBOUNCE_EN undefined:
  - No counters are built; q[i] = s[i] registered once.
  - Pin-to-q latency is SYNC_STAGES+1, identical to P=0.
  - Address 5 reads 0 and writes to it are ignored.
  - All other behaviour is unchanged.

## Test plan
- Reset with in_port=8'hA5, RISE_EN=0 → DATA reads 8'hA5 after 4 clocks; CAPTURE=0; irq=0.
- RISE_EN=8'h01, IRQ_MASK=8'h01, P=0; in_port[0] 0→1 → irq high exactly 3 clocks later; CAPTURE reads 8'h01. Write 3←8'h01 → irq low next cycle.
- FALL_EN=8'h02, RISE_EN=0; in_port[1] 1→0 sets CAPTURE[1]; a later 0→1 does not set it. Writing 3←8'h00 leaves CAPTURE=8'h02.
- P=10: 5-cycle pulse on in_port[2] → DATA and CAPTURE unchanged. A 20-cycle pulse → DATA[2]=1 at pin-edge+13 clocks.
- Edge on bit 3 in the same cycle as a W1C write of bit 3 → CAPTURE[3]=1. A W1C of bit 4 in the same cycle leaves bit 4 cleared.
- Assert reset_n mid-debounce with cnt=5 → all registers 0 and irq=0 immediately (asynchronous). After release, the debounce restarts from 0.
